// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver: blanking codes,
// active-low glyph table (g..a) and digit index type.
package seven_seg_scan_driver_pkg;

   localparam int IDX_W = 2;
   typedef logic [IDX_W-1:0] digit_idx_t;

   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [7:0] SEG_DASH   = 8'hBF;
   localparam logic [3:0] ANODE_OFF  = 4'b1111;
   localparam logic [6:0] SEG7_BLANK = SEG_BLANK[6:0];
   localparam logic [6:0] SEG7_DASH  = SEG_DASH[6:0];

   // Active-low g..a patterns, entry n is decimal digit n
   localparam logic [9:0][6:0] DIGIT_SEG = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Index 0 is the leftmost digit, driven by anode[3]
   function automatic logic [3:0] anode_for(input digit_idx_t idx);
      return ~(4'b1000 >> idx);
   endfunction

endpackage

// File: rtl/seven_seg_scan_driver_lut.sv
// BCD nibble to active-low seven-segment pattern (g..a); A-E blank, F is a dash.
module bcd_to_seg_lut
   import seven_seg_scan_driver_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG7_BLANK;
      if (bcd <= 4'd9) begin
         seg_n = DIGIT_SEG[bcd];
      end else if (bcd == 4'hF) begin
         seg_n = SEG7_DASH;
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed display driver: refresh scan with one blank cycle per
// digit change, per-frame snapshot of the inputs, and blink of the edit digit.
module seven_seg_scan_driver
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 250
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] num,
   input  logic [3:0]  sel,
   input  logic        blink_en,
   input  logic [3:0]  dp_mask,
   output logic [7:0]  seg,
   output logic [3:0]  anode,
   output logic        frame_tick
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic             blank_slot;
   logic             frame_wrap;
   digit_idx_t       idx;
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_phase;
   logic [15:0]      num_snap;
   logic [3:0]       sel_snap;
   logic [3:0]       dp_snap;

   assign tick       = (pre_cnt == PRE_LAST);
   assign frame_wrap = tick && (idx == digit_idx_t'(3));
   // The cycle that registers the digit change is driven dark to stop ghosting
   assign blank_slot = tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
         idx     <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
         idx     <= idx + digit_idx_t'(1);
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   // Frame registers change only at the 3->0 wrap, so a frame never mixes two values
   always_ff @(posedge clk) begin
      if (reset) begin
         num_snap <= '0;
         sel_snap <= '0;
         dp_snap  <= '0;
      end else if (frame_wrap) begin
         num_snap <= num;
         sel_snap <= sel;
         dp_snap  <= dp_mask;
      end
   end

   // ---- p0: digit select, decode, blink/blank masking ----
   digit_idx_t bit_pos;
   logic [3:0] nibble_p0;
   logic [6:0] glyph_p0;
   logic       hide_p0;
   logic [7:0] seg_p0;
   logic [3:0] anode_p0;

   // sel/dp_mask/num all number their digits from the left at the top bit
   assign bit_pos   = digit_idx_t'(3) - idx;
   assign nibble_p0 = num_snap[{bit_pos, 2'b00} +: 4];
   assign hide_p0   = blink_en & sel_snap[bit_pos] & blink_phase;

   bcd_to_seg_lut u_lut (
      .bcd   (nibble_p0),
      .seg_n (glyph_p0)
   );

   always_comb begin
      seg_p0   = SEG_BLANK;
      anode_p0 = ANODE_OFF;
      if (!blank_slot && !hide_p0) begin
         seg_p0   = {~dp_snap[bit_pos], glyph_p0};
         anode_p0 = anode_for(idx);
      end
   end

   // ---- p1: registered pin drive ----
   always_ff @(posedge clk) begin
      if (reset) begin
         seg        <= SEG_BLANK;
         anode      <= ANODE_OFF;
         frame_tick <= 1'b0;
      end else begin
         seg        <= seg_p0;
         anode      <= anode_p0;
         frame_tick <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=4, BLINK_DIV=2:
// every digit slot is three lit cycles followed by one dark cycle.
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] num;
   logic [3:0]  sel;
   logic        blink_en;
   logic [3:0]  dp_mask;
   logic [7:0]  seg;
   logic [3:0]  anode;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   localparam logic [3:0] A0  = 4'b0111;
   localparam logic [3:0] A1  = 4'b1011;
   localparam logic [3:0] A2  = 4'b1101;
   localparam logic [3:0] A3  = 4'b1110;
   localparam logic [3:0] OFF = 4'b1111;

   seven_seg_scan_driver #(
      .REFRESH_DIV (4),
      .BLINK_DIV   (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .num        (num),
      .sel        (sel),
      .blink_en   (blink_en),
      .dp_mask    (dp_mask),
      .seg        (seg),
      .anode      (anode),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] s, input logic [3:0] a, input logic ft);
      checks++;
      assert ({seg, anode, frame_tick} === {s, a, ft}) else begin
         errors++;
         $error("FAIL %s: got seg=%h anode=%b frame_tick=%b, want seg=%h anode=%b frame_tick=%b",
                tag, seg, anode, frame_tick, s, a, ft);
      end
   endtask

   // Three lit cycles of one digit, then the dark cycle carrying the optional frame pulse
   task automatic slot(input string tag, input logic [7:0] s, input logic [3:0] a, input logic ft);
      for (int i = 0; i < 3; i++) begin
         step();
         chk(tag, s, a, 1'b0);
      end
      step();
      chk({tag, "_gap"}, 8'hFF, OFF, ft);
   endtask

   initial begin
      reset    = 1'b1;
      num      = 16'h0000;
      sel      = 4'b0000;
      blink_en = 1'b0;
      dp_mask  = 4'b0000;
      repeat (3) begin
         step();
         chk("reset_hold", 8'hFF, OFF, 1'b0);
      end

      // Frame 0: snapshot still 0000
      reset = 1'b0;
      num   = 16'h1234;
      slot("f0_d0", 8'hC0, A0, 1'b0);
      slot("f0_d1", 8'hC0, A1, 1'b0);
      slot("f0_d2", 8'hC0, A2, 1'b0);
      slot("f0_d3", 8'hC0, A3, 1'b1);

      // Frame 1: 1234
      slot("f1_d0", 8'hF9, A0, 1'b0);
      slot("f1_d1", 8'hA4, A1, 1'b0);
      slot("f1_d2", 8'hB0, A2, 1'b0);
      slot("f1_d3", 8'h99, A3, 1'b1);

      // Frame 2: num changes mid-frame, remainder of frame keeps 1234
      slot("f2_d0", 8'hF9, A0, 1'b0);
      slot("f2_d1", 8'hA4, A1, 1'b0);
      num = 16'h5678;
      slot("f2_d2", 8'hB0, A2, 1'b0);
      slot("f2_d3", 8'h99, A3, 1'b1);

      // Frame 3: 5678; sel set late so it only takes effect next frame
      slot("f3_d0", 8'h92, A0, 1'b0);
      slot("f3_d1", 8'h82, A1, 1'b0);
      slot("f3_d2", 8'hF8, A2, 1'b0);
      sel      = 4'b0110;
      blink_en = 1'b1;
      slot("f3_d3", 8'h80, A3, 1'b1);

      // Frame 4: digits 0,1 fall in phase 0, digits 2,3 in phase 1
      slot("f4_d0", 8'h92, A0, 1'b0);
      slot("f4_d1_sel_on", 8'h82, A1, 1'b0);
      slot("f4_d2_sel_off", 8'hFF, OFF, 1'b0);
      slot("f4_d3_unsel", 8'h80, A3, 1'b1);

      // Frame 5: blink_en dropped before digit 2 slot
      slot("f5_d0", 8'h92, A0, 1'b0);
      slot("f5_d1", 8'h82, A1, 1'b0);
      blink_en = 1'b0;
      slot("f5_d2_noblink", 8'hF8, A2, 1'b0);
      num     = 16'hF0AF;
      dp_mask = 4'b0010;
      sel     = 4'b0010;
      slot("f5_d3", 8'h80, A3, 1'b1);

      // Frame 6: dash, 0, blank with dp, dash
      slot("f6_d0_dash", 8'hBF, A0, 1'b0);
      slot("f6_d1_zero", 8'hC0, A1, 1'b0);
      slot("f6_d2_dp", 8'h7F, A2, 1'b0);
      slot("f6_d3_dash", 8'hBF, A3, 1'b1);

      // Frame 7: digit 2 blink-blanked, its dp suppressed
      blink_en = 1'b1;
      slot("f7_d0", 8'hBF, A0, 1'b0);
      slot("f7_d1", 8'hC0, A1, 1'b0);
      slot("f7_d2_dp_hidden", 8'hFF, OFF, 1'b0);
      sel = 4'b1010;
      step();
      chk("f7_d3", 8'hBF, A3, 1'b0);

      // Reset while idx=3 and blink phase=1
      reset = 1'b1;
      step();
      chk("midscan_reset", 8'hFF, OFF, 1'b0);
      step();
      chk("midscan_reset_hold", 8'hFF, OFF, 1'b0);
      reset = 1'b0;

      // First frame after reset: cleared snapshot, nothing selected
      slot("r0_d0", 8'hC0, A0, 1'b0);
      slot("r0_d1", 8'hC0, A1, 1'b0);
      slot("r0_d2", 8'hC0, A2, 1'b0);
      slot("r0_d3", 8'hC0, A3, 1'b1);

      // Phase restarted at 0: digit 0 visible, digit 2 hidden
      slot("r1_d0_sel_on", 8'hBF, A0, 1'b0);
      slot("r1_d1", 8'hC0, A1, 1'b0);
      slot("r1_d2_sel_off", 8'hFF, OFF, 1'b0);
      slot("r1_d3", 8'hBF, A3, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
